// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - MIPS ID stage: decode, register file, branch resolve, hazards, ID/EX register
module instruction_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ifIdReg,
  input  logic        wbWriteEn,
  input  logic [4:0]  wbWriteReg,
  input  logic [31:0] wbWriteData,
  input  logic        exMemMemRead,
  input  logic [4:0]  exMemDest,
  output logic        branchResult,
  output logic [31:0] branchAddrs,
  output logic        regStall,
  output logic        muxStall,
  output logic [7:0]  idExCtrl,
  output logic [31:0] idExPcPlus4,
  output logic [31:0] idExRsData,
  output logic [31:0] idExRtData,
  output logic [31:0] idExImm,
  output logic [4:0]  idExRs,
  output logic [4:0]  idExRt,
  output logic [4:0]  idExRd,
  output logic [4:0]  idExDest
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  logic [31:0] instr, pcPlus4;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] regFile [32];
  logic [31:0] rsVal, rtVal, immExt, brTarget, jTarget;
  logic [7:0]  ctrl;
  logic        isR, isSw, isBeq, isBne, isJ, isBr, taken;
  logic        rsUse, rtUse, rsHaz, rtHaz, loadUse, brHaz, stall;

  assign instr   = ifIdReg[63:32];
  assign pcPlus4 = ifIdReg[31:0];
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm     = instr[15:0];
  assign target  = instr[25:0];
  assign immExt  = {{16{imm[15]}}, imm};

  always_comb begin
    ctrl  = 8'h00;
    isR   = 1'b0;
    isSw  = 1'b0;
    isBeq = 1'b0;
    isBne = 1'b0;
    isJ   = 1'b0;
    case (op)
      OP_R:    begin ctrl = 8'b1000_1010; isR = 1'b1; end
      OP_LW:   ctrl = 8'b1110_0100;
      OP_SW:   begin ctrl = 8'b0001_0100; isSw = 1'b1; end
      OP_ADDI: ctrl = 8'b1000_0100;
      OP_BEQ:  begin ctrl = 8'b0000_0001; isBeq = 1'b1; end
      OP_BNE:  begin ctrl = 8'b0000_0001; isBne = 1'b1; end
      OP_J:    isJ = 1'b1;
      default: ctrl = 8'h00;
    endcase
  end
  assign isBr = isBeq | isBne;

  // Write-back in the same cycle wins over the stored value, so branch compares see it too
  assign rsVal = (rs == 5'd0) ? 32'd0 :
                 (wbWriteEn && wbWriteReg == rs) ? wbWriteData : regFile[rs];
  assign rtVal = (rt == 5'd0) ? 32'd0 :
                 (wbWriteEn && wbWriteReg == rt) ? wbWriteData : regFile[rt];

  assign rsUse   = !isJ;
  assign rtUse   = isR | isSw | isBr;
  assign loadUse = idExCtrl[5] && (idExRt != 5'd0) &&
                   ((rsUse && idExRt == rs) || (rtUse && idExRt == rt));
  assign rsHaz   = (rs != 5'd0) && ((idExCtrl[7] && idExDest == rs) ||
                                    (exMemMemRead && exMemDest == rs));
  assign rtHaz   = (rt != 5'd0) && ((idExCtrl[7] && idExDest == rt) ||
                                    (exMemMemRead && exMemDest == rt));
  assign brHaz   = isBr && (rsHaz || rtHaz);
  assign stall   = loadUse | brHaz;
  assign regStall = stall;
  assign muxStall = stall;

  assign taken    = (isBeq && rsVal == rtVal) || (isBne && rsVal != rtVal);
  assign brTarget = pcPlus4 + {immExt[29:0], 2'b00};
  assign jTarget  = {pcPlus4[31:28], target, 2'b00};

  always_comb begin
    branchResult = 1'b0;
    branchAddrs  = 32'd0;
    if (!stall) begin
      if (isJ) begin
        branchResult = 1'b1;
        branchAddrs  = jTarget;
      end else if (taken) begin
        branchResult = 1'b1;
        branchAddrs  = brTarget;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if (wbWriteEn && wbWriteReg != 5'd0) begin
      regFile[wbWriteReg] <= wbWriteData;
    end
  end

  // A stall loads a bubble; redirecting instructions carry no control downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || stall) begin
      idExCtrl    <= 8'h00;
      idExPcPlus4 <= 32'd0;
      idExRsData  <= 32'd0;
      idExRtData  <= 32'd0;
      idExImm     <= 32'd0;
      idExRs      <= 5'd0;
      idExRt      <= 5'd0;
      idExRd      <= 5'd0;
      idExDest    <= 5'd0;
    end else begin
      idExCtrl    <= (isBr || isJ) ? 8'h00 : ctrl;
      idExPcPlus4 <= pcPlus4;
      idExRsData  <= rsVal;
      idExRtData  <= rtVal;
      idExImm     <= immExt;
      idExRs      <= rs;
      idExRt      <= rt;
      idExRd      <= rd;
      idExDest    <= ctrl[3] ? rd : rt;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - scoreboard bench for the ID stage
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ifIdReg;
  logic        wbWriteEn;
  logic [4:0]  wbWriteReg;
  logic [31:0] wbWriteData;
  logic        exMemMemRead;
  logic [4:0]  exMemDest;
  logic        branchResult;
  logic [31:0] branchAddrs;
  logic        regStall, muxStall;
  logic [7:0]  idExCtrl;
  logic [31:0] idExPcPlus4, idExRsData, idExRtData, idExImm;
  logic [4:0]  idExRs, idExRt, idExRd, idExDest;

  instruction_decode dut (
    .clk(clk), .rst_n(rst_n), .ifIdReg(ifIdReg),
    .wbWriteEn(wbWriteEn), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
    .exMemMemRead(exMemMemRead), .exMemDest(exMemDest),
    .branchResult(branchResult), .branchAddrs(branchAddrs),
    .regStall(regStall), .muxStall(muxStall),
    .idExCtrl(idExCtrl), .idExPcPlus4(idExPcPlus4), .idExRsData(idExRsData),
    .idExRtData(idExRtData), .idExImm(idExImm), .idExRs(idExRs),
    .idExRt(idExRt), .idExRd(idExRd), .idExDest(idExDest)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  logic [31:0]  mregs [32];
  logic [155:0] sbQ [$];
  logic [155:0] want;
  wire  [155:0] dutVec = {idExCtrl, idExPcPlus4, idExRsData, idExRtData, idExImm,
                          idExRs, idExRt, idExRd, idExDest};

  function automatic logic [31:0] rType(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic logic [31:0] rdReg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wbWriteEn && wbWriteReg == r) return wbWriteData;
    return mregs[r];
  endfunction

  function automatic logic [155:0] model(input logic [31:0] ins, input logic [31:0] pc4);
    logic [7:0] c;
    logic [5:0] o;
    o = ins[31:26];
    case (o)
      6'h00:   c = 8'h8A;
      6'h23:   c = 8'hE4;
      6'h2B:   c = 8'h14;
      6'h08:   c = 8'h84;
      default: c = 8'h00;
    endcase
    return {c, pc4, rdReg(ins[25:21]), rdReg(ins[20:16]), {{16{ins[15]}}, ins[15:0]},
            ins[25:21], ins[20:16], ins[15:11], (o == 6'h00) ? ins[15:11] : ins[20:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n && wbWriteEn && wbWriteReg != 5'd0) mregs[wbWriteReg] = wbWriteData;
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc4, input bit expStall);
    ifIdReg = {ins, pc4};
    sbQ.push_back(expStall ? 156'd0 : model(ins, pc4));
    #1;
  endtask

  task automatic wrReg(input logic [4:0] r, input logic [31:0] v);
    ifIdReg = 64'd0;
    wbWriteEn = 1'b1; wbWriteReg = r; wbWriteData = v;
    tick();
    wbWriteEn = 1'b0;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    sbQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifIdReg = 64'd0; wbWriteEn = 1'b0; wbWriteReg = 5'd0; wbWriteData = 32'd0;
    exMemMemRead = 1'b0; exMemDest = 5'd0;
    clearModel();
    #3;
    nCmp++; if (dutVec !== 156'd0) begin nBad++; $display("FAIL reset_idex got=%h want=0", dutVec); end
    nCmp++; if ({branchResult, branchAddrs, regStall, muxStall} !== 35'd0) begin
      nBad++; $display("FAIL reset_comb got=%b/%h/%b/%b want=0", branchResult, branchAddrs, regStall, muxStall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    wbWriteEn = 1'b1; wbWriteReg = 5'd5; wbWriteData = 32'h1234;
    drive(iType(6'h08, 5'd5, 5'd6, 16'd1), 32'h10, 1'b0);
    nCmp++; if (regStall !== 1'b0) begin nBad++; $display("FAIL bypass_stall got=%b want=0", regStall); end
    tick();
    wbWriteEn = 1'b0;
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL bypass_idex got=%h want=%h", dutVec, want); end
    nCmp++; if ({idExCtrl, idExRsData, idExImm} !== {8'h84, 32'h1234, 32'd1}) begin
      nBad++; $display("FAIL bypass_fields got=%h/%h/%h want=84/1234/1", idExCtrl, idExRsData, idExImm);
    end
    drive(rType(5'd5, 5'd5, 5'd7), 32'h14, 1'b0);
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL stored_read got=%h want=%h", dutVec, want); end
  endtask

  task automatic test_load_use();
    wrReg(5'd1, 32'h100);
    wrReg(5'd4, 32'd5);
    drive(iType(6'h23, 5'd1, 5'd2, 16'd0), 32'h20, 1'b0);
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL lw_idex got=%h want=%h", dutVec, want); end
    drive(rType(5'd2, 5'd4, 5'd3), 32'h24, 1'b1);
    nCmp++; if ({regStall, muxStall} !== 2'b11) begin
      nBad++; $display("FAIL loaduse_stall got=%b%b want=11", regStall, muxStall);
    end
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL loaduse_bubble got=%h want=%h", dutVec, want); end
    drive(rType(5'd2, 5'd4, 5'd3), 32'h24, 1'b0);
    nCmp++; if (regStall !== 1'b0) begin nBad++; $display("FAIL loaduse_len got=%b want=0", regStall); end
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL loaduse_issue got=%h want=%h", dutVec, want); end
  endtask

  task automatic test_branch();
    wrReg(5'd1, 32'd7);
    wrReg(5'd2, 32'd7);
    drive(iType(6'h04, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0);
    nCmp++; if ({branchResult, branchAddrs} !== {1'b1, 32'h4C}) begin
      nBad++; $display("FAIL beq_taken got=%b/%h want=1/0000004c", branchResult, branchAddrs);
    end
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want || idExCtrl !== 8'h00) begin nBad++; $display("FAIL beq_idex got=%h want=%h", dutVec, want); end
    wrReg(5'd2, 32'd8);
    drive(iType(6'h04, 5'd1, 5'd2, 16'd3), 32'h40, 1'b0);
    nCmp++; if ({branchResult, branchAddrs} !== 33'd0) begin
      nBad++; $display("FAIL beq_not_taken got=%b/%h want=0/0", branchResult, branchAddrs);
    end
    tick();
    void'(sbQ.pop_front());
    drive(iType(6'h05, 5'd1, 5'd2, 16'hFFFE), 32'h100, 1'b0);
    nCmp++; if ({branchResult, branchAddrs} !== {1'b1, 32'hF8}) begin
      nBad++; $display("FAIL bne_back got=%b/%h want=1/000000f8", branchResult, branchAddrs);
    end
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL bne_idex got=%h want=%h", dutVec, want); end
  endtask

  task automatic test_branch_after_load();
    drive(iType(6'h23, 5'd0, 5'd1, 16'd0), 32'h60, 1'b0);
    tick();
    void'(sbQ.pop_front());
    for (int c = 0; c < 2; c++) begin
      exMemMemRead = (c == 1); exMemDest = (c == 1) ? 5'd1 : 5'd0;
      drive(iType(6'h04, 5'd1, 5'd0, 16'd4), 32'h64, 1'b1);
      nCmp++; if ({regStall, branchResult} !== 2'b10) begin
        nBad++; $display("FAIL brload_stall%0d got=%b%b want=10", c, regStall, branchResult);
      end
      tick();
      want = sbQ.pop_front();
      nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL brload_bubble%0d got=%h want=%h", c, dutVec, want); end
    end
    exMemMemRead = 1'b0; exMemDest = 5'd0;
    wbWriteEn = 1'b1; wbWriteReg = 5'd1; wbWriteData = 32'd0;
    drive(iType(6'h04, 5'd1, 5'd0, 16'd4), 32'h64, 1'b0);
    nCmp++; if ({regStall, branchResult, branchAddrs} !== {2'b01, 32'h74}) begin
      nBad++; $display("FAIL brload_resolve got=%b%b/%h want=01/00000074", regStall, branchResult, branchAddrs);
    end
    tick();
    wbWriteEn = 1'b0;
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL brload_idex got=%h want=%h", dutVec, want); end
  endtask

  task automatic test_jump();
    drive({6'h02, 26'h10}, 32'h8000_0004, 1'b0);
    nCmp++; if ({branchResult, branchAddrs} !== {1'b1, 32'h8000_0040}) begin
      nBad++; $display("FAIL jump got=%b/%h want=1/80000040", branchResult, branchAddrs);
    end
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want || idExCtrl !== 8'h00) begin nBad++; $display("FAIL jump_idex got=%h want=%h", dutVec, want); end
    drive(iType(6'h23, 5'd0, 5'd3, 16'd0), 32'h90, 1'b0);
    tick();
    void'(sbQ.pop_front());
    drive({6'h02, 26'h060_0010}, 32'h8000_0004, 1'b0);
    nCmp++; if ({regStall, branchResult, branchAddrs} !== {2'b01, 32'h8180_0040}) begin
      nBad++; $display("FAIL jump_after_lw got=%b%b/%h want=01/81800040", regStall, branchResult, branchAddrs);
    end
    tick();
    void'(sbQ.pop_front());
    drive(iType(6'h3F, 5'd1, 5'd2, 16'h1234), 32'hA0, 1'b0);
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want || idExCtrl !== 8'h00) begin nBad++; $display("FAIL unknown_op got=%h want=%h", dutVec, want); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [3];
    logic [31:0] ins;
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h2B;
    for (int n = 0; n < 24; n++) begin
      ins = {ops[$urandom_range(2)], 5'($urandom), 5'($urandom), 16'($urandom)};
      wbWriteEn = 1'($urandom); wbWriteReg = 5'($urandom); wbWriteData = $urandom;
      drive(ins, 32'h1000 + 32'(n * 4), 1'b0);
      nCmp++; if (regStall !== 1'b0) begin nBad++; $display("FAIL b2b_stall%0d got=%b want=0", n, regStall); end
      tick();
      want = sbQ.pop_front();
      nCmp++; if (dutVec !== want) begin nBad++; $display("FAIL b2b_idex%0d got=%h want=%h", n, dutVec, want); end
    end
    wbWriteEn = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    wrReg(5'd5, 32'hCAFE);
    drive(iType(6'h23, 5'd0, 5'd2, 16'd0), 32'hB0, 1'b0);
    tick();
    void'(sbQ.pop_front());
    ifIdReg = {rType(5'd2, 5'd4, 5'd3), 32'hB4};
    #1;
    nCmp++; if (regStall !== 1'b1) begin nBad++; $display("FAIL midrst_prestall got=%b want=1", regStall); end
    rst_n = 1'b0;
    #1;
    nCmp++; if (dutVec !== 156'd0 || regStall !== 1'b0) begin
      nBad++; $display("FAIL midrst_idex got=%h/%b want=0/0", dutVec, regStall);
    end
    @(posedge clk); #1;
    clearModel();
    rst_n = 1'b1;
    drive(rType(5'd5, 5'd0, 5'd7), 32'hC0, 1'b0);
    tick();
    want = sbQ.pop_front();
    nCmp++; if (dutVec !== want || idExRsData !== 32'd0) begin
      nBad++; $display("FAIL midrst_regclear got=%h want=%h", dutVec, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_branch();
    test_branch_after_load();
    test_jump();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
